// File: rtl/rd_fifo_tx_pacer_pkg.sv
// Types and helpers shared by the SDRAM read path and the UART transmit side.
package uart_sdram_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, TAIL} pacer_state_e;

    localparam int BYTE_W          = 8;
    localparam int UART_FRAME_BITS = 10;

    // Clock cycles spanned by one UART frame: start bit, 8 data bits, stop bit.
    function automatic int frame_cyc(input int clk_freq, input int uart_bps);
        return UART_FRAME_BITS * (clk_freq / uart_bps);
    endfunction

endpackage

// File: rtl/rd_fifo_tx_pacer_if.sv
// Read-FIFO side and UART-strobe side of the pacer, bundled as one port.
interface rd_fifo_tx_pacer_if #(
    parameter int NUM_W = 10
) ();
    import uart_sdram_pkg::*;

    logic [NUM_W-1:0]  rd_fifo_num;
    logic [BYTE_W-1:0] pi_data;
    logic              read_en;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_flag;

    modport master (
        input  rd_fifo_num,
        input  pi_data,
        output read_en,
        output tx_data,
        output tx_flag
    );

    modport slave (
        output rd_fifo_num,
        output pi_data,
        input  read_en,
        input  tx_data,
        input  tx_flag
    );

endinterface

// File: rtl/rd_fifo_tx_pacer_burst_buf.sv
// Single-clock byte FIFO holding one burst; the read port is registered.
module burst_buf
    import uart_sdram_pkg::*;
#(
    parameter int BUF_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [BYTE_W-1:0] rd_data
);

    logic [BYTE_W-1:0] mem [0:(2**BUF_AW)-1];
    logic [BUF_AW-1:0] wr_ptr_q;
    logic [BUF_AW-1:0] rd_ptr_q;
    logic [BYTE_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // A one-byte burst is popped on the same edge it is written, so forward it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= (wr_en && (wr_ptr_q == rd_ptr_q)) ? wr_data : mem[rd_ptr_q];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/rd_fifo_tx_pacer.sv
// Fetches one burst from the SDRAM read FIFO, then replays it to the UART
// transmitter with one byte strobe per UART frame.
module rd_fifo_tx_pacer
    import uart_sdram_pkg::*;
#(
    parameter int BURST_NUM = 10,
    parameter int UART_BPS  = 9600,
    parameter int CLK_FREQ  = 50_000_000,
    parameter int NUM_W     = 10,
    parameter int BUF_AW    = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    rd_fifo_tx_pacer_if.master fifo_if
);

    localparam int FRAME_CYC = frame_cyc(CLK_FREQ, UART_BPS);
    localparam int CNT_W     = $clog2(FRAME_CYC);
    localparam int FCH_W     = $clog2(BURST_NUM + 1);

    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYC - 1);
    localparam logic [FCH_W-1:0] BURST_CNT  = FCH_W'(BURST_NUM);
    localparam logic [NUM_W-1:0] BURST_LVL  = NUM_W'(BURST_NUM);

    if (BURST_NUM < 1) begin : g_chk_burst
        $error("rd_fifo_tx_pacer: BURST_NUM must be at least 1");
    end
    if ((2 ** BUF_AW) < BURST_NUM) begin : g_chk_buf
        $error("rd_fifo_tx_pacer: buffer of 2**BUF_AW bytes cannot hold BURST_NUM");
    end
    if ((CLK_FREQ / UART_BPS) < 1) begin : g_chk_baud
        $error("rd_fifo_tx_pacer: CLK_FREQ must be at least UART_BPS");
    end

    pacer_state_e      state_q, state_d;
    logic [FCH_W-1:0]  fetch_cnt_q, fetch_cnt_d;
    logic [FCH_W-1:0]  pop_cnt_q, pop_cnt_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic              read_en_q, read_en_d;
    logic              rd_dly_q;
    logic              tx_flag_q, tx_flag_d;
    logic              buf_clr;
    logic              buf_pop;
    logic [BYTE_W-1:0] buf_rd_data;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            fetch_cnt_q <= '0;
            pop_cnt_q   <= '0;
            frame_cnt_q <= '0;
            read_en_q   <= 1'b0;
            rd_dly_q    <= 1'b0;
            tx_flag_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_cnt_q <= fetch_cnt_d;
            pop_cnt_q   <= pop_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            read_en_q   <= read_en_d;
            rd_dly_q    <= read_en_q;
            tx_flag_q   <= tx_flag_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_cnt_d = fetch_cnt_q;
        pop_cnt_d   = pop_cnt_q;
        frame_cnt_d = frame_cnt_q;
        read_en_d   = 1'b0;
        tx_flag_d   = 1'b0;
        buf_clr     = 1'b0;
        buf_pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fifo_if.rd_fifo_num >= BURST_LVL) begin
                    state_d     = FETCH;
                    read_en_d   = 1'b1;
                    fetch_cnt_d = FCH_W'(1);
                end
            end
            FETCH: begin
                if (fetch_cnt_q != BURST_CNT) begin
                    read_en_d   = 1'b1;
                    fetch_cnt_d = fetch_cnt_q + 1'b1;
                end
                // Delayed read strobe falling marks the last write; the first byte goes out now.
                if (rd_dly_q && !read_en_q) begin
                    state_d     = DRAIN;
                    buf_pop     = 1'b1;
                    tx_flag_d   = 1'b1;
                    pop_cnt_d   = FCH_W'(1);
                    frame_cnt_d = '0;
                end
            end
            DRAIN: begin
                frame_cnt_d = (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + 1'b1;
                if (pop_cnt_q == BURST_CNT) begin
                    state_d = TAIL;
                end else if (frame_cnt_q == FRAME_LAST) begin
                    buf_pop   = 1'b1;
                    tx_flag_d = 1'b1;
                    pop_cnt_d = pop_cnt_q + 1'b1;
                end
            end
            TAIL: begin
                if (frame_cnt_q == FRAME_LAST) begin
                    state_d     = IDLE;
                    buf_clr     = 1'b1;
                    frame_cnt_d = '0;
                    pop_cnt_d   = '0;
                    fetch_cnt_d = '0;
                end else begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    burst_buf #(
        .BUF_AW (BUF_AW)
    ) u_burst_buf (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .clr     (buf_clr),
        .wr_en   (rd_dly_q),
        .wr_data (fifo_if.pi_data),
        .rd_en   (buf_pop),
        .rd_data (buf_rd_data)
    );

    assign fifo_if.read_en = read_en_q;
    assign fifo_if.tx_flag = tx_flag_q;
    assign fifo_if.tx_data = buf_rd_data;

endmodule

// File: tb/tb_rd_fifo_tx_pacer.sv
// Scoreboard bench: two pacers (10-byte and 1-byte bursts, 100-cycle frames).
module tb_rd_fifo_tx_pacer;

    localparam int F  = 100;   // 10 * (1000 / 100)
    localparam int BA = 10;
    localparam int BB = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;
    int rd_cnt_a    = 0;
    int rd_cnt_b    = 0;

    typedef struct {
        logic [7:0] data;
        int         at;
    } exp_t;

    exp_t       exp_a[$];
    exp_t       exp_b[$];
    logic [7:0] fifo_a[$];
    logic [7:0] fifo_b[$];

    rd_fifo_tx_pacer_if #(.NUM_W(10)) if_a ();
    rd_fifo_tx_pacer_if #(.NUM_W(10)) if_b ();

    rd_fifo_tx_pacer #(
        .BURST_NUM (BA), .UART_BPS (100), .CLK_FREQ (1000), .NUM_W (10), .BUF_AW (4)
    ) dut_a (
        .sys_clk (clk), .sys_rst (rst_a), .fifo_if (if_a)
    );

    rd_fifo_tx_pacer #(
        .BURST_NUM (BB), .UART_BPS (100), .CLK_FREQ (1000), .NUM_W (10), .BUF_AW (1)
    ) dut_b (
        .sys_clk (clk), .sys_rst (rst_b), .fifo_if (if_b)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Non-show-ahead read FIFO models: data appears the cycle after read_en.
    always @(posedge clk) begin
        if (if_a.read_en === 1'b1) begin
            if (fifo_a.size() > 0) if_a.pi_data <= fifo_a.pop_front();
            else                   if_a.pi_data <= 8'h00;
        end
        if (if_b.read_en === 1'b1) begin
            if (fifo_b.size() > 0) if_b.pi_data <= fifo_b.pop_front();
            else                   if_b.pi_data <= 8'h00;
        end
    end

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (if_a.read_en === 1'b1) rd_cnt_a++;
        if (if_a.tx_flag === 1'b1) begin
            $display("A pulse: tx_data=0x%02h at cycle %0d", if_a.tx_data, cyc);
            if (exp_a.size() == 0) begin
                check("a_unexpected_pulse", if_a.tx_flag, 1'b0);
            end else begin
                e = exp_a.pop_front();
                check("a_tx_data", if_a.tx_data, e.data);
                check("a_pulse_cycle", cyc, e.at);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (if_b.read_en === 1'b1) rd_cnt_b++;
        if (if_b.tx_flag === 1'b1) begin
            $display("B pulse: tx_data=0x%02h at cycle %0d", if_b.tx_data, cyc);
            if (exp_b.size() == 0) begin
                check("b_unexpected_pulse", if_b.tx_flag, 1'b0);
            end else begin
                e = exp_b.pop_front();
                check("b_tx_data", if_b.tx_data, e.data);
                check("b_pulse_cycle", cyc, e.at);
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_empty_a(input int budget);
        int n = 0;
        while (exp_a.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("a_drain_timeout", exp_a.size(), 0);
    endtask

    task automatic wait_empty_b(input int budget);
        int n = 0;
        while (exp_b.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("b_drain_timeout", exp_b.size(), 0);
    endtask

    task automatic push_a(input logic [7:0] d, input int at);
        exp_t e;
        e.data = d;
        e.at   = at;
        exp_a.push_back(e);
    endtask

    task automatic push_b(input logic [7:0] d, input int at);
        exp_t e;
        e.data = d;
        e.at   = at;
        exp_b.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before cycle 20000");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int k2;
        int base;
        logic [7:0] b;

        rst_a = 1'b1;
        rst_b = 1'b1;
        if_a.rd_fifo_num = '0;
        if_b.rd_fifo_num = '0;
        repeat (3) @(negedge clk);
        check("a_rst_read_en", if_a.read_en, 1'b0);
        check("a_rst_tx_flag", if_a.tx_flag, 1'b0);
        check("a_rst_tx_data", if_a.tx_data, 8'h00);
        check("b_rst_read_en", if_b.read_en, 1'b0);
        check("b_rst_tx_flag", if_b.tx_flag, 1'b0);
        check("b_rst_tx_data", if_b.tx_data, 8'h00);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Fill level one short of a burst must never start a fetch.
        if_a.rd_fifo_num = 10'd9;
        base = rd_cnt_a;
        repeat (1000) @(negedge clk);
        check("a_below_burst_reads", rd_cnt_a - base, 0);

        // One full burst: read window, byte order and pulse spacing.
        for (int i = 0; i < BA; i++) begin
            b = 8'h31 + 8'(i);
            fifo_a.push_back(b);
        end
        k = cyc + 1;
        if_a.rd_fifo_num = 10'd10;
        for (int n = 0; n < BA; n++) begin
            b = 8'h31 + 8'(n);
            push_a(b, k + BA + 1 + n * F);
        end
        for (int c = k - 1; c <= k + BA; c++) begin
            wait_until(c);
            check("a_read_en_window", if_a.read_en, (c >= k && c < k + BA) ? 1'b1 : 1'b0);
        end
        if_a.rd_fifo_num = '0;
        wait_empty_a(BA * F + 100);
        wait_until(k + BA + 2 + BA * F);

        // Twenty bytes waiting: two back-to-back rounds of ten.
        for (int i = 0; i < 2 * BA; i++) begin
            b = 8'h41 + 8'(i);
            fifo_a.push_back(b);
        end
        k  = cyc + 1;
        k2 = k + BA + 2 + BA * F;
        if_a.rd_fifo_num = 10'd20;
        for (int n = 0; n < 2 * BA; n++) begin
            b = 8'h41 + 8'(n);
            push_a(b, ((n < BA) ? k : k2) + BA + 1 + (n % BA) * F);
        end
        wait_until(k + BA);
        check("a_round1_read_en_end", if_a.read_en, 1'b0);
        wait_until(k2 - 1);
        check("a_round2_not_early", if_a.read_en, 1'b0);
        wait_until(k2);
        check("a_round2_read_en_start", if_a.read_en, 1'b1);
        wait_until(k2 + BA);
        check("a_round2_read_en_end", if_a.read_en, 1'b0);
        if_a.rd_fifo_num = '0;
        wait_empty_a(2 * BA * F + 100);
        wait_until(k2 + BA + 2 + BA * F);

        // Reset in the middle of a round, right in the third pulse cycle.
        for (int i = 0; i < BA; i++) begin
            b = 8'h61 + 8'(i);
            fifo_a.push_back(b);
        end
        k = cyc + 1;
        if_a.rd_fifo_num = 10'd10;
        for (int n = 0; n < 3; n++) begin
            b = 8'h61 + 8'(n);
            push_a(b, k + BA + 1 + n * F);
        end
        wait_until(k + BA + 1 + 2 * F);
        if_a.rd_fifo_num = '0;
        #2;
        rst_a = 1'b1;
        #1;
        check("a_midrst_tx_flag", if_a.tx_flag, 1'b0);
        check("a_midrst_tx_data", if_a.tx_data, 8'h00);
        check("a_midrst_read_en", if_a.read_en, 1'b0);
        check("a_midrst_pending", exp_a.size(), 0);
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        fifo_a.delete();
        base = rd_cnt_a;
        repeat (300) @(negedge clk);
        check("a_post_reset_reads", rd_cnt_a - base, 0);

        // Fresh round after reset starts from its own first byte.
        for (int i = 0; i < BA; i++) begin
            b = 8'h71 + 8'(i);
            fifo_a.push_back(b);
        end
        k = cyc + 1;
        if_a.rd_fifo_num = 10'd10;
        for (int n = 0; n < BA; n++) begin
            b = 8'h71 + 8'(n);
            push_a(b, k + BA + 1 + n * F);
        end
        wait_until(k + BA);
        if_a.rd_fifo_num = '0;
        wait_empty_a(BA * F + 100);
        check("a_total_reads", rd_cnt_a, 50);

        // One-byte bursts: 3-cycle latency, 100-cycle re-sample, level toggling ignored.
        fifo_b.push_back(8'h5A);
        fifo_b.push_back(8'hA5);
        k = cyc + 1;
        if_b.rd_fifo_num = 10'd1;
        push_b(8'h5A, k + 2);
        push_b(8'hA5, k + 103 + 2);
        wait_until(k);
        check("b_read_en_on", if_b.read_en, 1'b1);
        for (int c = k + 1; c <= k + 90; c++) begin
            wait_until(c);
            if (c == k + 1) check("b_read_en_single", if_b.read_en, 1'b0);
            if_b.rd_fifo_num = 10'(c % 2);
        end
        if_b.rd_fifo_num = 10'd1;
        wait_until(k + 102);
        check("b_no_early_sample", if_b.read_en, 1'b0);
        wait_until(k + 103);
        check("b_resample_read_en", if_b.read_en, 1'b1);
        wait_until(k + 104);
        if_b.rd_fifo_num = '0;
        check("b_read_en_single2", if_b.read_en, 1'b0);
        wait_empty_b(300);
        repeat (150) @(negedge clk);
        check("b_total_reads", rd_cnt_b, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
